// File: rtl/call_stack.sv
// call_stack: return-address stack feeding the PC mux; top_addr is read combinationally during a pop.
// Define CALL_STACK_WRAP_EN to let a push while full overwrite the oldest entry instead of dropping it.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                push_addr,
  output logic [AW-1:0]                top_addr,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int SPW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           mem_we_d;
  logic [SPW-1:0] mem_idx_d;
  logic [SPW-1:0] top_idx;
  logic           is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign top_idx  = sp_q - SP_ONE;

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we_d    = 1'b0;
    mem_idx_d   = sp_q;

    if (push && pop) begin
      // Simultaneous push/pop replaces the top; on an empty stack it is a plain push.
      if (is_empty) begin
        mem_we_d = 1'b1;
        sp_d     = sp_q + SP_ONE;
        count_d  = count_q + CNT_ONE;
      end else begin
        mem_we_d  = 1'b1;
        mem_idx_d = top_idx;
      end
    end else if (push) begin
      if (!is_full) begin
        mem_we_d = 1'b1;
        sp_d     = sp_q + SP_ONE;
        count_d  = count_q + CNT_ONE;
      end else begin
        overflow_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
        // sp already points at the oldest slot when full, so this overwrites it.
        mem_we_d = 1'b1;
        sp_d     = sp_q + SP_ONE;
`endif
      end
    end else if (pop) begin
      if (!is_empty) begin
        sp_d    = sp_q - SP_ONE;
        count_d = count_q - CNT_ONE;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we_d) begin
      mem_q[mem_idx_d] <= push_addr;
    end
  end

  assign top_addr  = is_empty ? '0 : mem_q[top_idx];
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  push_addr_known: assert property (@(posedge clk) push |-> !$isunknown(push_addr));

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: table-driven directed vectors, full/overflow sequence, and randomized run
// against a queue-based return-stack model. Honours CALL_STACK_WRAP_EN like the design.
module tb_call_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 12;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] top_addr;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_pass   = 0;

  call_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          p;
    logic          o;
    logic [AW-1:0] addr;
    logic [AW-1:0] rd_top;
    logic [CW-1:0] cnt;
    logic [AW-1:0] top;
    logic          e;
    logic          f;
    logic          ov;
    logic          un;
  } vec_t;

  vec_t vecs [20];

  // Reference model: the stack is a queue whose back is the top.
  logic [AW-1:0] mdl_q [$];
  logic          mdl_ov;
  logic          mdl_un;

  function automatic logic [AW-1:0] mdlTop();
    if (mdl_q.size() == 0) return '0;
    return mdl_q[mdl_q.size()-1];
  endfunction

  task automatic mdlStep(input logic r, input logic p, input logic o, input logic [AW-1:0] a);
    if (r) begin
      mdl_q.delete();
      mdl_ov = 1'b0;
      mdl_un = 1'b0;
    end else if (p && o) begin
      if (mdl_q.size() == 0) mdl_q.push_back(a);
      else mdl_q[mdl_q.size()-1] = a;
    end else if (p) begin
      if (mdl_q.size() < DEPTH) mdl_q.push_back(a);
      else begin
        mdl_ov = 1'b1;
`ifdef CALL_STACK_WRAP_EN
        void'(mdl_q.pop_front());
        mdl_q.push_back(a);
`endif
      end
    end else if (o) begin
      if (mdl_q.size() > 0) void'(mdl_q.pop_back());
      else mdl_un = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic checkState(input string tag, input logic [CW-1:0] c, input logic [AW-1:0] t,
                            input logic e, input logic f, input logic ov, input logic un);
    checkOutput({tag, ".count"},     32'(count),     32'(c));
    checkOutput({tag, ".top_addr"},  32'(top_addr),  32'(t));
    checkOutput({tag, ".empty"},     32'(empty),     32'(e));
    checkOutput({tag, ".full"},      32'(full),      32'(f));
    checkOutput({tag, ".overflow"},  32'(overflow),  32'(ov));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(un));
  endtask

  // Drive one cycle; when popping, the returned address is checked before the edge.
  task automatic applyStimulus(input string tag, input logic r, input logic p, input logic o,
                               input logic [AW-1:0] a, input logic [AW-1:0] rd_exp);
    @(negedge clk);
    rst       = r;
    push      = p;
    pop       = o;
    push_addr = a;
    #1;
    if (o) checkOutput({tag, ".rd_top"}, 32'(top_addr), 32'(rd_exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0;
    mdl_ov = 1'b0; mdl_un = 1'b0;

    //          r     p     o     addr     rd_top   cnt   top      e     f     ov    un
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 12'h010, 12'h000, 4'd1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 12'h020, 12'h000, 4'd2, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 12'h030, 12'h000, 4'd3, 12'h030, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h030, 4'd2, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h020, 4'd1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h010, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 12'h044, 12'h000, 4'd1, 12'h044, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 12'h0A0, 12'h000, 4'd1, 12'h0A0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 12'h0B0, 12'h0A0, 4'd1, 12'h0B0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h0B0, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 12'h0C0, 12'h000, 4'd1, 12'h0C0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 12'h011, 12'h000, 4'd1, 12'h011, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 12'h022, 12'h000, 4'd2, 12'h022, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 12'h033, 12'h000, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};

    $display("[TB] directed vector table");
    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].r, vecs[i].p, vecs[i].o, vecs[i].addr, vecs[i].rd_top);
      checkState($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].top, vecs[i].e, vecs[i].f, vecs[i].ov, vecs[i].un);
    end

    $display("[TB] fill and push while full");
    applyStimulus("fill_rst", 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] a;
      a = 12'h100 + 12'(i);
      applyStimulus("fill", 1'b0, 1'b1, 1'b0, a, '0);
    end
    checkState("filled", 4'd8, 12'h107, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("ovf_push", 1'b0, 1'b1, 1'b0, 12'h1FF, '0);
`ifdef CALL_STACK_WRAP_EN
    checkState("ovf_push", 4'd8, 12'h1FF, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("drain0", 1'b0, 1'b0, 1'b1, '0, 12'h1FF);
    for (int i = 0; i < DEPTH-1; i++) begin
      logic [AW-1:0] e;
      e = 12'h107 - 12'(i);
      applyStimulus("drain", 1'b0, 1'b0, 1'b1, '0, e);
    end
`else
    checkState("ovf_push", 4'd8, 12'h107, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] e;
      e = 12'h107 - 12'(i);
      applyStimulus("drain", 1'b0, 1'b0, 1'b1, '0, e);
    end
`endif
    checkState("drained", 4'd0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] randomized run against model");
    applyStimulus("rnd_rst", 1'b1, 1'b0, 1'b0, '0, '0);
    mdlStep(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 600; i++) begin
      int pp, po;
      logic r, p, o;
      logic [AW-1:0] a, rd;
      pp = ((i / 60) % 2 == 0) ? 70 : 30;
      po = 100 - pp;
      r  = ($urandom_range(0, 79) == 0);
      p  = ($urandom_range(0, 99) < pp);
      o  = ($urandom_range(0, 99) < po);
      a  = AW'($urandom);
      rd = mdlTop();
      applyStimulus("rnd", r, p, o, a, rd);
      mdlStep(r, p, o, a);
      checkState("rnd", CW'(mdl_q.size()), mdlTop(), mdl_q.size() == 0,
                 mdl_q.size() == DEPTH, mdl_ov, mdl_un);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack that sits directly downstream of the instruction controller.
- Consumes the controller's push/pop strobes:
  - push is asserted on call instructions, together with selRet=2'b10 and selpc=1.
  - pop is asserted on return instructions, together with selRet=2'b01.
- On a call it stores the return PC supplied by the datapath.
- It drives the current top-of-stack back to the PC mux, so a return selects it in the same cycle that pop is asserted.
- Tracks depth and flags overflow/underflow for debug and test.

Parameters:
- DEPTH, 8, number of return-address entries; power of two, minimum 2.
- AW, 12, width of a PC / return address in bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  store push_addr as new top this cycle.
- pop  input  1  discard current top this cycle.
- push_addr  input  AW  return address to store, normally PC+1.
- top_addr  output  AW  current top entry; combinational from stack state; 0 when empty.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- overflow  output  1  sticky flag: a push was attempted while full.
- underflow  output  1  sticky flag: a pop was attempted while empty.

Behaviour:
- State:
  - mem[0..DEPTH-1] of AW bits.
  - write pointer sp, $clog2(DEPTH) bits, modulo DEPTH.
  - count.
  - sticky flags overflow and underflow.
- Reset (rst=1 at a clk edge):
  - sp=0, count=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, top_addr=0.
  - mem contents are don't-care.
  - Reset has priority over push/pop in the same cycle; a reset in mid-sequence discards all entries.
- top_addr = mem[(sp-1) mod DEPTH] when count>0, else 0.
  - No read latency: a return reads top_addr in the same cycle pop is high.
  - The popped value is removed at that cycle's edge.
- Push only (push=1, pop=0):
  - Not full: mem[sp]<=push_addr, sp<=sp+1, count<=count+1. The new value is visible on top_addr the next cycle.
  - Full: stack unchanged, overflow<=1 (default build).
- Pop only (pop=1, push=0):
  - Not empty: sp<=sp-1, count<=count-1.
  - Empty: no state change, underflow<=1.
- Push and pop in the same cycle (not issued by the controller; defined for robustness):
  - Not empty: replace top, i.e. mem[sp-1]<=push_addr. sp and count are unchanged and no flag is set.
  - Empty: treated as push only, with no underflow.
- Neither asserted: hold all state.
- Sticky flags clear only on rst.
- Pointer arithmetic wraps modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- Simulation assertion: push_addr must be known (no X) whenever push=1.

Optional Feature:
- Macro: CALL_STACK_WRAP_EN.
- Defined: a push while full overwrites the oldest entry.
  - mem[sp]<=push_addr, sp<=sp+1, count stays DEPTH, overflow<=1.
  - The most recent DEPTH return addresses remain poppable, in LIFO order.
- Not defined: a push while full is dropped, as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, top_addr=0, overflow=0, underflow=0.
- Push 0x010, 0x020, 0x030 on consecutive cycles:
  - top_addr=0x030 and count=3 afterwards.
  - Pops read 0x030, 0x020, 0x010 in the pop cycles.
  - empty=1 after the third pop.
- With DEPTH=8, push 0x100..0x107, then push 0x1FF:
  - Default build: full=1, count=8, top_addr=0x107, overflow=1.
  - CALL_STACK_WRAP_EN: top_addr=0x1FF, overflow=1. Eight pops yield 0x1FF, 0x107..0x101.
- Pop while empty → underflow=1, count=0, top_addr=0. The flag stays 1 after subsequent valid pushes until rst.
- Push 0x0A0, then push=pop=1 with push_addr=0x0B0 → count=1, top_addr=0x0B0. Then push=pop=1 while empty → count=1, underflow=0.
- Push 0x011, 0x022, then assert rst in the same cycle as push 0x033 → next cycle count=0, empty=1, top_addr=0, flags 0.
